// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl -- pipeline hazard / stall / flush controller.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   load_use              load-use hazard from the hazard unit
//   branch_taken          taken branch resolved in EX
//   mc_busy               multi-cycle EX unit still computing
//   halt_req, resume      HALT decoded in ID / leave HALT
//   pc_we, if_id_we, id_ex_we                  write enables
//   if_id_flush, id_ex_flush, ex_mem_flush     bubble inserts
//   halted                core halted
//   state[2:0]            RUN=0 LD_STALL=1 MC_WAIT=2 DRAIN=3 HALT=4
//   stall_cycles[15:0]    stall performance counter
//
// Parameters: LOAD_STALL_CYC (1..7) bubbles per load-use hazard,
//             DRAIN_CYC (1..7) drain cycles before HALT.
// Define PIPELINE_CTRL_PERF_EN to build the saturating stall counter;
// without it stall_cycles is tied to zero.
module pipeline_ctrl #(
  parameter int LOAD_STALL_CYC = 1,
  parameter int DRAIN_CYC      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_use,
  input  logic        branch_taken,
  input  logic        mc_busy,
  input  logic        halt_req,
  input  logic        resume,
  output logic        pc_we,
  output logic        if_id_we,
  output logic        id_ex_we,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] stall_cycles
);

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_STALL = 3'd1,
    MC_WAIT  = 3'd2,
    DRAIN    = 3'd3,
    HALT     = 3'd4
  } st_e;

  // Output bundle: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic id_ex_we;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic halted;
  } ctl_t;

  localparam ctl_t CTL_DEF = 7'b111_000_0;
  localparam ctl_t CTL_BR  = 7'b111_110_0;  // squash IF/ID and ID/EX
  localparam ctl_t CTL_MC  = 7'b000_001_0;  // freeze front, bubble into MEM
  localparam ctl_t CTL_LU  = 7'b001_010_0;  // hold PC/IF-ID, bubble into EX
  localparam ctl_t CTL_DR  = 7'b011_100_0;  // stop fetch, let older ops drain
  localparam ctl_t CTL_HLT = 7'b000_000_1;
  localparam ctl_t CTL_RST = 7'b000_111_0;

  localparam logic [2:0] LS_LOAD = 3'(LOAD_STALL_CYC - 1);
  localparam logic [2:0] DR_LOAD = 3'(DRAIN_CYC);

  st_e        st_q, st_d;
  logic [2:0] cnt_q, cnt_d;
  ctl_t       ctl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= RUN;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    ctl   = CTL_DEF;
    st_d  = st_q;
    cnt_d = cnt_q;
    case (st_q)
      RUN: begin
        if (branch_taken) begin
          ctl   = CTL_BR;
          cnt_d = '0;
        end else if (mc_busy) begin
          ctl  = CTL_MC;
          st_d = MC_WAIT;
        end else if (halt_req) begin
          ctl   = CTL_DR;
          cnt_d = DR_LOAD;
          st_d  = DRAIN;
        end else if (load_use) begin
          ctl = CTL_LU;
          // The hazard cycle itself is the first bubble.
          if (LOAD_STALL_CYC > 1) begin
            cnt_d = LS_LOAD;
            st_d  = LD_STALL;
          end
        end
      end
      LD_STALL: begin
        if (branch_taken) begin
          ctl   = CTL_BR;
          cnt_d = '0;
          st_d  = RUN;
        end else begin
          ctl   = CTL_LU;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d = '0;
            st_d  = RUN;
          end
        end
      end
      MC_WAIT: begin
        if (branch_taken) begin
          ctl   = CTL_BR;
          cnt_d = '0;
          st_d  = RUN;
        end else if (mc_busy) begin
          ctl = CTL_MC;
        end else begin
          st_d = RUN;  // release in the same cycle mc_busy drops
        end
      end
      DRAIN: begin
        if (branch_taken) begin
          ctl   = CTL_BR;
          cnt_d = '0;
          st_d  = RUN;
        end else if (mc_busy) begin
          ctl = CTL_MC;  // drain cannot progress; counter holds
        end else begin
          ctl   = CTL_DR;
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d = '0;
            st_d  = HALT;
          end
        end
      end
      HALT: begin
        ctl = CTL_HLT;
        if (resume) st_d = RUN;
      end
      default: begin
        st_d  = RUN;
        cnt_d = '0;
      end
    endcase
    // Reset overrides combinationally so the pipe is frozen and flushed
    // without waiting for a clock.
    if (reset) ctl = CTL_RST;
  end

  assign pc_we        = ctl.pc_we;
  assign if_id_we     = ctl.if_id_we;
  assign id_ex_we     = ctl.id_ex_we;
  assign if_id_flush  = ctl.if_id_flush;
  assign id_ex_flush  = ctl.id_ex_flush;
  assign ex_mem_flush = ctl.ex_mem_flush;
  assign halted       = ctl.halted;
  assign state        = st_q;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else if (!pc_we && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end

  assign stall_cycles = perf_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_ctrl;

`ifdef PIPELINE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Expected bundle order: {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, halted}
  localparam logic [6:0] E_DEF = 7'b111_000_0;
  localparam logic [6:0] E_BR  = 7'b111_110_0;
  localparam logic [6:0] E_MC  = 7'b000_001_0;
  localparam logic [6:0] E_LU  = 7'b001_010_0;
  localparam logic [6:0] E_DR  = 7'b011_100_0;
  localparam logic [6:0] E_HLT = 7'b000_000_1;
  localparam logic [6:0] E_RST = 7'b000_111_0;

  logic clk, reset, load_use, branch_taken, mc_busy, halt_req, resume;
  logic pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, halted;
  logic [2:0]  state;
  logic [15:0] stall_cycles;

  pipeline_ctrl #(.LOAD_STALL_CYC(2), .DRAIN_CYC(3)) dut (
    .clk(clk), .reset(reset), .load_use(load_use), .branch_taken(branch_taken),
    .mc_busy(mc_busy), .halt_req(halt_req), .resume(resume),
    .pc_we(pc_we), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .halted(halted), .state(state), .stall_cycles(stall_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [6:0]  ctl;
    logic [2:0]  st;
    bit          chk_stall;
    logic [15:0] stall;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   total  = 0;
  int   passed = 0;

  // Monitor: drains the scoreboard on each falling edge, or immediately
  // when the driver wants a mid-cycle sample (asynchronous reset).
  exp_t       m_e;
  logic [6:0] m_got;
  initial begin
    forever begin
      @(negedge clk or sample_ev);
      while (q.size() > 0) begin
        m_e   = q.pop_front();
        m_got = {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_flush, ex_mem_flush, halted};
        total++;
        if (m_got !== m_e.ctl || state !== m_e.st ||
            (m_e.chk_stall && stall_cycles !== m_e.stall))
          $display("FAIL %s: got ctl=%b state=%0d stall=%h, expected ctl=%b state=%0d stall=%h",
                   m_e.name, m_got, state, stall_cycles, m_e.ctl, m_e.st, m_e.stall);
        else
          passed++;
      end
    end
  end

  task automatic push(string n, logic [6:0] c, logic [2:0] s, bit cs, logic [15:0] sv);
    exp_t e;
    e.name = n; e.ctl = c; e.st = s; e.chk_stall = cs; e.stall = sv;
    q.push_back(e);
  endtask

  // One clock of stimulus; expectation is the combinational response in that cycle.
  task automatic cyc(string n, logic lu, logic br, logic mc, logic hr, logic rs,
                     logic [6:0] c, logic [2:0] s);
    @(posedge clk);
    #1;
    load_use = lu; branch_taken = br; mc_busy = mc; halt_req = hr; resume = rs;
    push(n, c, s, !PERF, 16'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d entries pending", q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; load_use = 0; branch_taken = 0; mc_busy = 0; halt_req = 0; resume = 0;
    #2 reset = 1'b1;
    #1 push("reset_async", E_RST, 3'd0, 1'b1, 16'h0); -> sample_ev;
    @(posedge clk); #1 push("reset_held", E_RST, 3'd0, 1'b1, 16'h0);
    @(negedge clk); #1 reset = 1'b0;

    //       name          lu br mc hr rs  outputs  state
    cyc("idle",          0, 0, 0, 0, 0, E_DEF, 3'd0);
    // load-use, two bubbles
    cyc("lu_hit",        1, 0, 0, 0, 0, E_LU,  3'd0);
    cyc("lu_stall",      0, 0, 0, 0, 0, E_LU,  3'd1);
    cyc("lu_done",       0, 0, 0, 0, 0, E_DEF, 3'd0);
    // multi-cycle EX busy for 4 cycles
    cyc("mc_1",          0, 0, 1, 0, 0, E_MC,  3'd0);
    cyc("mc_2",          0, 0, 1, 0, 0, E_MC,  3'd2);
    cyc("mc_3",          0, 0, 1, 0, 0, E_MC,  3'd2);
    cyc("mc_4",          0, 0, 1, 0, 0, E_MC,  3'd2);
    cyc("mc_release",    0, 0, 0, 0, 0, E_DEF, 3'd2);
    cyc("mc_run",        0, 0, 0, 0, 0, E_DEF, 3'd0);
    // branch beats load-use; branch aborts LD_STALL
    cyc("br_over_lu",    1, 1, 0, 0, 0, E_BR,  3'd0);
    cyc("br_next_run",   0, 0, 0, 0, 0, E_DEF, 3'd0);
    cyc("lu_again",      1, 0, 0, 0, 0, E_LU,  3'd0);
    cyc("br_in_ldstall", 0, 1, 0, 0, 0, E_BR,  3'd1);
    cyc("br_ld_exit",    0, 0, 0, 0, 0, E_DEF, 3'd0);
    // mc_busy beats load-use
    cyc("mc_over_lu",    1, 0, 1, 0, 0, E_MC,  3'd0);
    cyc("mc_over_lu_rl", 0, 0, 0, 0, 0, E_DEF, 3'd2);
    // halt with load-use also present, drain 3, halt, ignore inputs, resume
    cyc("halt_req",      1, 0, 0, 1, 0, E_DR,  3'd0);
    cyc("drain_1",       0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("drain_2",       0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("drain_3",       0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("halted",        0, 0, 0, 0, 0, E_HLT, 3'd4);
    cyc("halt_ignore",   1, 1, 1, 1, 0, E_HLT, 3'd4);
    cyc("halt_resume",   0, 0, 0, 0, 1, E_HLT, 3'd4);
    cyc("resumed",       0, 0, 0, 0, 0, E_DEF, 3'd0);
    // mc_busy freezes the drain counter
    cyc("halt_req_b",    0, 0, 0, 1, 0, E_DR,  3'd0);
    cyc("drainb_1",      0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("drainb_mc",     0, 0, 1, 0, 0, E_MC,  3'd3);
    cyc("drainb_2",      0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("drainb_3",      0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("haltedb",       0, 0, 0, 0, 0, E_HLT, 3'd4);
    cyc("resume_b",      0, 0, 0, 0, 1, E_HLT, 3'd4);
    cyc("resumed_b",     0, 0, 0, 0, 0, E_DEF, 3'd0);
    // reset asynchronously in the middle of the 2nd drain cycle
    cyc("halt_req_c",    0, 0, 0, 1, 0, E_DR,  3'd0);
    cyc("drainc_1",      0, 0, 0, 0, 0, E_DR,  3'd3);
    cyc("drainc_2",      0, 0, 0, 0, 0, E_DR,  3'd3);
    @(negedge clk); #1 reset = 1'b1;
    #1 push("reset_mid_drain", E_RST, 3'd0, 1'b1, 16'h0); -> sample_ev;
    @(negedge clk); #1 reset = 1'b0;
    cyc("after_reset",   0, 0, 0, 0, 0, E_DEF, 3'd0);

    // stall counter: long mc_busy stall, saturating (or tied to 0)
    @(posedge clk); #1 reset = 1'b1;
    #1 push("perf_reset", E_RST, 3'd0, 1'b1, 16'h0); -> sample_ev;
    @(negedge clk); #1 reset = 1'b0; mc_busy = 1'b1;
    #1 push("perf_start", E_MC, 3'd0, 1'b1, 16'h0); -> sample_ev;
    repeat (10) @(posedge clk);
    #1 push("perf_10", E_MC, 3'd2, 1'b1, PERF ? 16'd10 : 16'd0); -> sample_ev;
    repeat (70000) @(posedge clk);
    #1 push("perf_sat", E_MC, 3'd2, 1'b1, PERF ? 16'hFFFF : 16'd0); -> sample_ev;
    #2 mc_busy = 1'b0;

    @(negedge clk); #1;
    if (q.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations never checked, expected 0", q.size());
      total += q.size();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
